// File: rtl/enemy_sprite_fetch_if.sv
// -----------------------------------------------------------------------------
// enemy_sprite_fetch_if
//
// Groups every signal that enemy_sprite_fetch exchanges with the rest of the
// VGA pixel path into one bundle:
//   - scan side   : frame_start, video_on, pixel_x, pixel_y
//   - fleet state : fleet_x, fleet_y, alive_mask
//   - ROM bus     : rom_type, rom_addr (to the sprite ROM), rom_data (back)
//   - pixel mux   : enemy_rgb, enemy_hit, enemy_index
//
// Modports:
//   master : the surroundings (scan generator, game logic and sprite ROM)
//   slave  : the enemy_sprite_fetch block itself
//
// N_ENEMY must equal COLS*ROWS of the attached enemy_sprite_fetch.
// -----------------------------------------------------------------------------
interface enemy_sprite_fetch_if #(
  parameter int N_ENEMY = 15
);
  // scan side
  logic               frame_start;
  logic               video_on;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  // fleet state from game logic
  logic [9:0]         fleet_x;
  logic [9:0]         fleet_y;
  logic [N_ENEMY-1:0] alive_mask;
  // sprite ROM bus
  logic [1:0]         rom_type;
  logic [11:0]        rom_addr;
  logic [11:0]        rom_data;
  // towards the pixel mux
  logic [11:0]        enemy_rgb;
  logic               enemy_hit;
  logic [3:0]         enemy_index;

  modport master (
    output frame_start, video_on, pixel_x, pixel_y,
    output fleet_x, fleet_y, alive_mask,
    output rom_data,
    input  rom_type, rom_addr,
    input  enemy_rgb, enemy_hit, enemy_index
  );

  modport slave (
    input  frame_start, video_on, pixel_x, pixel_y,
    input  fleet_x, fleet_y, alive_mask,
    input  rom_data,
    output rom_type, rom_addr,
    output enemy_rgb, enemy_hit, enemy_index
  );
endinterface

// File: rtl/enemy_sprite_fetch.sv
// -----------------------------------------------------------------------------
// enemy_sprite_fetch
//
// Maps the current VGA scan pixel onto the enemy fleet grid, addresses the
// enemy sprite ROM, and re-aligns the ROM's one-cycle read latency with the
// side-band flags so the pixel mux receives a colour, a hit flag and the index
// of the enemy under the beam.
//
// Fleet position and alive mask are latched once per frame (on frame_start),
// so game-logic updates during the visible frame never tear the picture.
// A frame counter drives a two-phase animation that rotates the sprite type
// offered to the ROM.
//
// Ports:
//   clk  : system clock
//   rst  : synchronous reset, active-high
//   bus  : enemy_sprite_fetch_if.slave
//          in  frame_start, video_on, pixel_x, pixel_y,
//              fleet_x, fleet_y, alive_mask, rom_data
//          out rom_type, rom_addr, enemy_rgb, enemy_hit, enemy_index
//
// Timing: a pixel sampled on edge 0 drives rom_addr/rom_type after edge 0,
// the ROM registers its data on edge 1, and enemy_rgb/hit/index update on
// edge 2. One pixel per clock, no stalls.
// -----------------------------------------------------------------------------
module enemy_sprite_fetch #(
  parameter int          SPRITE_W    = 39,
  parameter int          SPRITE_H    = 39,
  parameter int          COLS        = 5,
  parameter int          ROWS        = 3,
  parameter int          GAP_X       = 12,
  parameter int          GAP_Y       = 10,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  parameter int          ANIM_FRAMES = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  enemy_sprite_fetch_if.slave  bus
);

  localparam int N_ENEMY = COLS * ROWS;
  localparam int PITCH_X = SPRITE_W + GAP_X;
  localparam int PITCH_Y = SPRITE_H + GAP_Y;
  localparam int CNT_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

  // ---------------------------------------------------------------------------
  // Per-frame latched state
  // ---------------------------------------------------------------------------
  logic [9:0]         fleet_x_q, fleet_x_d;
  logic [9:0]         fleet_y_q, fleet_y_d;
  logic [N_ENEMY-1:0] alive_q, alive_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               anim_q, anim_d;

  always_comb begin
    fleet_x_d   = fleet_x_q;
    fleet_y_d   = fleet_y_q;
    alive_d     = alive_q;
    frame_cnt_d = frame_cnt_q;
    anim_d      = anim_q;
    if (bus.frame_start) begin
      fleet_x_d = bus.fleet_x;
      fleet_y_d = bus.fleet_y;
      alive_d   = bus.alive_mask;
      if (frame_cnt_q == CNT_W'(ANIM_FRAMES - 1)) begin
        frame_cnt_d = '0;
        anim_d      = ~anim_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Geometry. Offsets are taken with an extra borrow bit so a pixel left of /
  // above the fleet is flagged as negative instead of wrapping to a large
  // positive offset that could land inside the grid.
  // ---------------------------------------------------------------------------
  logic [10:0] dx_ext, dy_ext;
  logic        dx_neg, dy_neg;
  logic [9:0]  dx, dy;

  assign dx_ext = {1'b0, bus.pixel_x} - {1'b0, fleet_x_q};
  assign dy_ext = {1'b0, bus.pixel_y} - {1'b0, fleet_y_q};
  assign dx_neg = dx_ext[10];
  assign dy_neg = dy_ext[10];
  assign dx     = dx_ext[9:0];
  assign dy     = dy_ext[9:0];

  // Threshold compares replace the divider: col_ge[k] says the offset has
  // reached the start of cell k. The last one (k = COLS / ROWS) marks the
  // offset as past the right / bottom edge of the grid.
  logic [COLS:1] col_ge;
  logic [ROWS:1] row_ge;

  genvar gi;
  generate
    for (gi = 1; gi <= COLS; gi++) begin : g_col_thr
      assign col_ge[gi] = 16'(dx) >= 16'(gi * PITCH_X);
    end
    for (gi = 1; gi <= ROWS; gi++) begin : g_row_thr
      assign row_ge[gi] = 16'(dy) >= 16'(gi * PITCH_Y);
    end
  endgenerate

  // Highest reached cell gives the quotient; its start gives the remainder.
  logic [3:0]  col_w, row_w;
  logic [10:0] col_base, row_base;
  logic [10:0] rx_w, ry_w;

  always_comb begin
    col_w    = '0;
    col_base = '0;
    for (int c = 1; c < COLS; c++) begin
      if (col_ge[c]) begin
        col_w    = 4'(c);
        col_base = 11'(c * PITCH_X);
      end
    end
    rx_w = {1'b0, dx} - col_base;
  end

  always_comb begin
    row_w    = '0;
    row_base = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (row_ge[r]) begin
        row_w    = 4'(r);
        row_base = 11'(r * PITCH_Y);
      end
    end
    ry_w = {1'b0, dy} - row_base;
  end

  logic        col_ok, row_ok, in_sprite;
  logic [3:0]  index_w;
  logic [15:0] alive_ext;
  logic        inside_w;
  logic [11:0] addr_w;
  logic [4:0]  type_sum;

  assign col_ok    = ~dx_neg & ~col_ge[COLS];
  assign row_ok    = ~dy_neg & ~row_ge[ROWS];
  assign in_sprite = (rx_w < 11'(SPRITE_W)) & (ry_w < 11'(SPRITE_H));
  // COLS*ROWS <= 16, so the enemy number always fits four bits; the mask is
  // zero-padded to 16 so any index value selects a defined bit.
  assign index_w   = row_w * 4'(COLS) + col_w;
  assign alive_ext = 16'(alive_q);
  assign inside_w  = bus.video_on & col_ok & row_ok & in_sprite & alive_ext[index_w];
  assign addr_w    = 12'(ry_w) * 12'(SPRITE_W) + 12'(rx_w);
  assign type_sum  = 5'(row_w) + 5'(anim_q);

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  // stage 1: ROM request plus side-band
  logic [11:0] rom_addr_q, rom_addr_d;
  logic [1:0]  rom_type_q, rom_type_d;
  logic        inside1_q, inside1_d;
  logic [3:0]  index1_q, index1_d;
  // stage 2: side-band waits while the ROM registers its data
  logic        inside2_q, inside2_d;
  logic [3:0]  index2_q, index2_d;
  // stage 3: outputs to the pixel mux
  logic        hit_q, hit_d;
  logic [11:0] rgb_q, rgb_d;
  logic [3:0]  idx_q, idx_d;

  always_comb begin
    // Outside pixels drive address/type 0 so the ROM bus stays quiet.
    rom_addr_d = inside_w ? addr_w : 12'd0;
    rom_type_d = inside_w ? 2'(type_sum % 5'd3) : 2'd0;
    inside1_d  = inside_w;
    index1_d   = index_w;

    inside2_d  = inside1_q;
    index2_d   = index1_q;

    hit_d      = inside2_q && (bus.rom_data != TRANSPARENT);
    rgb_d      = hit_d ? bus.rom_data : 12'd0;
    idx_d      = hit_d ? index2_q : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fleet_x_q   <= '0;
      fleet_y_q   <= '0;
      alive_q     <= '0;
      frame_cnt_q <= '0;
      anim_q      <= 1'b0;
      rom_addr_q  <= '0;
      rom_type_q  <= '0;
      inside1_q   <= 1'b0;
      index1_q    <= '0;
      inside2_q   <= 1'b0;
      index2_q    <= '0;
      hit_q       <= 1'b0;
      rgb_q       <= '0;
      idx_q       <= '0;
    end else begin
      fleet_x_q   <= fleet_x_d;
      fleet_y_q   <= fleet_y_d;
      alive_q     <= alive_d;
      frame_cnt_q <= frame_cnt_d;
      anim_q      <= anim_d;
      rom_addr_q  <= rom_addr_d;
      rom_type_q  <= rom_type_d;
      inside1_q   <= inside1_d;
      index1_q    <= index1_d;
      inside2_q   <= inside2_d;
      index2_q    <= index2_d;
      hit_q       <= hit_d;
      rgb_q       <= rgb_d;
      idx_q       <= idx_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.rom_type    = rom_type_q;
  assign bus.enemy_hit   = hit_q;
  assign bus.enemy_rgb   = rgb_q;
  assign bus.enemy_index = idx_q;

endmodule

// File: tb/tb_enemy_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_enemy_sprite_fetch
//
// Drives enemy_sprite_fetch with directed scenes followed by random pixels,
// plays the sprite ROM itself (registered read), and checks every cycle
// against a plain-arithmetic model of the fleet grid.
// -----------------------------------------------------------------------------
module tb_enemy_sprite_fetch;

  localparam int SW    = 39;
  localparam int SH    = 39;
  localparam int COLS  = 5;
  localparam int ROWS  = 3;
  localparam int PX    = 39 + 12;
  localparam int PY    = 39 + 10;
  localparam int AF    = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;

  enemy_sprite_fetch_if #(.N_ENEMY(COLS * ROWS)) bus ();

  enemy_sprite_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Stub sprite ROM: {type, addr} -> colour, one edge of latency.
  logic [11:0] rom_mem [0:16383];
  always @(posedge clk) bus.rom_data <= rom_mem[{bus.rom_type, bus.rom_addr}];

  int checks = 0;
  int errors = 0;

  // Inputs as the game logic presents them (may change mid-frame).
  int          fx_in, fy_in;
  logic [14:0] alive_in;

  // Model state: what the block should have latched.
  int          m_fx, m_fy, m_cnt;
  logic [14:0] m_alive;
  int          m_anim;

  typedef struct packed {
    logic        hit;
    logic [11:0] rgb;
    logic [3:0]  idx;
  } exp_t;

  exp_t pipe [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: present a pixel, model it, advance, compare.
  task automatic step(input bit r, input bit fs, input bit vo, input int x, input int y);
    int   dx, dy, col, row, rx, ry;
    int   ea, et, ei;
    bit   ins;
    exp_t e, o;

    rst             = r;
    bus.frame_start = fs;
    bus.video_on    = vo;
    bus.pixel_x     = 10'(x);
    bus.pixel_y     = 10'(y);
    bus.fleet_x     = 10'(fx_in);
    bus.fleet_y     = 10'(fy_in);
    bus.alive_mask  = alive_in;

    ins = 1'b0; ea = 0; et = 0; ei = 0;
    dx = x - m_fx;
    dy = y - m_fy;
    if (vo && dx >= 0 && dy >= 0) begin
      col = dx / PX; rx = dx % PX;
      row = dy / PY; ry = dy % PY;
      if (col < COLS && row < ROWS && rx < SW && ry < SH) begin
        if (m_alive[row * COLS + col]) begin
          ins = 1'b1;
          ea  = ry * SW + rx;
          et  = (row + m_anim) % 3;
          ei  = row * COLS + col;
        end
      end
    end
    e.hit = ins && (rom_mem[et * 4096 + ea] != 12'h000);
    e.rgb = e.hit ? rom_mem[et * 4096 + ea] : 12'h000;
    e.idx = e.hit ? 4'(ei) : 4'h0;

    @(posedge clk);
    #1;

    if (r) begin
      chk("rst_addr", 32'(bus.rom_addr), 32'h0);
      chk("rst_type", 32'(bus.rom_type), 32'h0);
      chk("rst_hit", 32'(bus.enemy_hit), 32'h0);
      chk("rst_rgb", 32'(bus.enemy_rgb), 32'h0);
      chk("rst_idx", 32'(bus.enemy_index), 32'h0);
      pipe.delete();
      pipe.push_back('0);
      pipe.push_back('0);
      m_fx = 0; m_fy = 0; m_alive = '0; m_cnt = 0; m_anim = 0;
    end else begin
      chk($sformatf("addr(%0d,%0d)", x, y), 32'(bus.rom_addr), 32'(ea));
      chk($sformatf("type(%0d,%0d)", x, y), 32'(bus.rom_type), 32'(et));
      pipe.push_back(e);
      o = pipe.pop_front();
      chk("hit", 32'(bus.enemy_hit), 32'(o.hit));
      chk("rgb", 32'(bus.enemy_rgb), 32'(o.rgb));
      chk("idx", 32'(bus.enemy_index), 32'(o.idx));
      if (fs) begin
        m_fx    = fx_in;
        m_fy    = fy_in;
        m_alive = alive_in;
        if (m_cnt == AF - 1) begin
          m_cnt  = 0;
          m_anim = 1 - m_anim;
        end else begin
          m_cnt++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int x, y;
    bit fs, vo, r;

    for (int i = 0; i < 16384; i++) rom_mem[i] = 12'hF00;
    fx_in = 0; fy_in = 0; alive_in = '0;
    m_fx = 0; m_fy = 0; m_alive = '0; m_cnt = 0; m_anim = 0;

    // 1: reset, then sweep with no frame latched -> nothing hits
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, i * 37, i * 23);
    step(0, 0, 1, 0, 0);
    idle(2);

    // 2: fleet at (100,50), all alive, ROM opaque red
    fx_in = 100; fy_in = 50; alive_in = 15'h7fff;
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 100, 50);
    chk("t2_addr", 32'(bus.rom_addr), 32'd0);
    idle(2);
    chk("t2_rgb", 32'(bus.enemy_rgb), 32'hF00);

    // 3: corner, gap, second row/column
    step(0, 0, 1, 138, 88);
    chk("t3_addr_max", 32'(bus.rom_addr), 32'd1520);
    step(0, 0, 1, 139, 50);
    step(0, 0, 1, 151, 99);
    chk("t3_type_row1", 32'(bus.rom_type), 32'd1);
    idle(2);
    chk("t3_idx6", 32'(bus.enemy_index), 32'd6);

    // 4: transparent pixel and one pixel left of the fleet
    rom_mem[0] = 12'h000;
    step(0, 0, 1, 100, 50);
    step(0, 0, 1, 99, 50);
    idle(2);

    // 5: alive change takes effect only at the next frame
    alive_in[6] = 1'b0;
    step(0, 0, 1, 151, 99);
    idle(2);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 151, 99);
    idle(2);
    chk("t5_dead_hit", 32'(bus.enemy_hit), 32'd0);

    // reset mid-line flushes the pipeline
    step(0, 0, 1, 120, 60);
    step(1, 0, 0, 0, 0);

    // 6: animation phase after 30 and 60 frames
    rom_mem[0] = 12'hF00;
    alive_in = 15'h7fff;
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 100, 50);
    chk("t6_row0_30", 32'(bus.rom_type), 32'd1);
    step(0, 0, 1, 100, 148);
    chk("t6_row2_30", 32'(bus.rom_type), 32'd0);
    for (int i = 0; i < 30; i++) step(0, 1, 0, 0, 0);
    step(0, 0, 1, 100, 50);
    chk("t6_row0_60", 32'(bus.rom_type), 32'd0);
    idle(2);

    // random phase: random ROM, fleet moves, frames, resets
    for (int i = 0; i < 16384; i++)
      rom_mem[i] = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        fx_in    = int'($urandom_range(0, 800));
        fy_in    = int'($urandom_range(0, 400));
        alive_in = 15'($urandom);
      end
      fs = ($urandom_range(0, 15) == 0);
      vo = ($urandom_range(0, 7) != 0);
      r  = ($urandom_range(0, 299) == 0);
      x  = m_fx + int'($urandom_range(0, 280)) - 20;
      y  = m_fy + int'($urandom_range(0, 170)) - 20;
      if (x < 0) x = 0;
      if (x > 1023) x = 1023;
      if (y < 0) y = 0;
      if (y > 1023) y = 1023;
      step(r, fs, vo, x, y);
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
